// File: rtl/neosd_dat_lane_reg.sv
// SD DAT lane shifter: byte-parallel load, 1..LANES bit serial shift, per-lane CRC16 generation.
// Latency: data_p_o/crc_o update one clk_i edge after load/shift; data_s_o is combinational from data_p_o.
// Backpressure: none; the shift pace is set entirely by clkstrb_i & shift_s_i, and load always wins.
//
// Ports:
//   clk_i, rst_i     - clock, synchronous active-high reset
//   clkstrb_i        - one-cycle strobe per slow SD clock period
//   wide_i           - lane mode captured on load (0: lane 0 only, 1: all LANES lanes)
//   dir_i            - CRC source: 0 = data_s_i (receive), 1 = data_s_o (transmit)
//   data_p_i/load_p_i/data_p_o - parallel byte load and shift register contents
//   shift_s_i        - shift enable, qualified by clkstrb_i
//   data_s_i/data_s_o - serial lanes, lane index = bit index; unused lanes drive 1
//   byte_done_o      - one-cycle pulse the cycle after the shift that completes a byte
//   crc_clr_i/crc_o  - clear all CRCs / per-lane CRC16, lane n at [16n+15:16n]
module neosd_dat_lane_reg #(
    parameter int LANES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clkstrb_i,
    input  logic                 wide_i,
    input  logic                 dir_i,
    input  logic [7:0]           data_p_i,
    input  logic                 load_p_i,
    output logic [7:0]           data_p_o,
    input  logic                 shift_s_i,
    input  logic [LANES-1:0]     data_s_i,
    output logic [LANES-1:0]     data_s_o,
    output logic                 byte_done_o,
    input  logic                 crc_clr_i,
    output logic [16*LANES-1:0]  crc_o
);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
            $error("neosd_dat_lane_reg: LANES must be 1, 2, 4 or 8");
        end
    endgenerate

    logic [7:0]          data_q, data_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                wide_q, wide_d;
    logic                done_q, done_d;
    logic [16*LANES-1:0] crc_q, crc_d;

    logic [3:0]          w;         // active lane count, 1..8
    logic [2:0]          cnt_last;  // counter value on the last shift of a byte
    logic [7:0]          din8;      // data_s_i padded to 8 bits so a full-width shift never indexes past LANES
    logic [7:0]          shifted;
    logic                shift_en;
    logic [15:0]         lane_crc;
    logic                fb;
    logic                crc_bit;

    always_comb begin
        w        = wide_q ? 4'(LANES) : 4'd1;
        cnt_last = wide_q ? 3'(8 / LANES - 1) : 3'd7;
        shift_en = clkstrb_i & shift_s_i & ~load_p_i;
        din8     = '1;
        din8[LANES-1:0] = data_s_i;
    end

    // Lane k carries the k-th bit of the top W bits; inactive lanes idle high.
    always_comb begin
        data_s_o = '1;
        for (int k = 0; k < LANES; k++) begin
            if (4'(k) < w) begin
                data_s_o[k] = data_q[3'(4'd8 - w + 4'(k))];
            end
        end
    end

    // Left shift by W with the incoming lane bits filling the bottom.
    always_comb begin
        shifted = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < w) begin
                shifted[i] = din8[i];
            end else begin
                shifted[i] = data_q[3'(4'(i) - w)];
            end
        end
    end

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        wide_d = wide_q;
        done_d = 1'b0;
        if (load_p_i) begin
            data_d = data_p_i;
            wide_d = wide_i;
            cnt_d  = 3'd0;
        end else if (shift_en) begin
            data_d = shifted;
            if (cnt_q == cnt_last) begin
                cnt_d  = 3'd0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    // Per-lane CRC16 (0x1021, MSB first). In transmit mode the bit is the one
    // currently on the lane, i.e. before this shift takes effect.
    always_comb begin
        crc_d    = crc_q;
        lane_crc = '0;
        fb       = 1'b0;
        crc_bit  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            lane_crc = crc_q[16*k +: 16];
            if (shift_en && (4'(k) < w)) begin
                crc_bit  = dir_i ? data_s_o[k] : data_s_i[k];
                fb       = lane_crc[15] ^ crc_bit;
                lane_crc = {lane_crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
            if (crc_clr_i) begin
                lane_crc = '0;
            end
            crc_d[16*k +: 16] = lane_crc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= 8'hFF;
            cnt_q  <= 3'd0;
            wide_q <= 1'b0;
            done_q <= 1'b0;
            crc_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            wide_q <= wide_d;
            done_q <= done_d;
            crc_q  <= crc_d;
        end
    end

    assign data_p_o    = data_q;
    assign byte_done_o = done_q;
    assign crc_o       = crc_q;

endmodule

// File: doc/neosd_dat_lane_reg.md
NEOSD_DAT_LANE_REG -- requirements
Module: neosd_dat_lane_reg

Interface
REQ-001 Parameter LANES, default 4, number of SD DAT lanes; SHALL be one of 1, 2, 4, 8; any other value is an elaboration error.
REQ-002 clk_i  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 clkstrb_i  input  1  single-cycle strobe marking one slow SD clock period.
REQ-005 wide_i  input  1  lane mode request: 0 = lane 0 only, 1 = all LANES lanes; sampled only on load.
REQ-006 dir_i  input  1  CRC source select: 0 = receive (data_s_i), 1 = transmit (data_s_o).
REQ-007 data_p_i  input  8  parallel byte to load.
REQ-008 load_p_i  input  1  load data_p_i into the shift register.
REQ-009 data_p_o  output  8  shift register contents.
REQ-010 shift_s_i  input  1  shift enable; qualified by clkstrb_i.
REQ-011 data_s_i  input  LANES  serial input bits, lane index = bit index.
REQ-012 data_s_o  output  LANES  serial output bits.
REQ-013 byte_done_o  output  1  one-cycle pulse when a byte has been fully shifted.
REQ-014 crc_clr_i  input  1  clear all lane CRCs.
REQ-015 crc_o  output  16*LANES  per-lane CRC16; lane n occupies bits [16n+15:16n].

Function
REQ-016 Effective lane count W SHALL be LANES when the registered mode is wide, else 1; shifts per byte N = 8/W.
REQ-017 Load (load_p_i=1) SHALL set data_p_o <= data_p_i, register wide_i as the mode, clear the shift counter, take priority over any shift in the same cycle, and not clock the CRCs.
REQ-018 Shift SHALL occur only in cycles with clkstrb_i=1, shift_s_i=1, load_p_i=0; clkstrb_i alone or shift_s_i alone SHALL change nothing.
REQ-019 On shift: data_p_o <= {data_p_o[7-W:0], data_s_i[W-1:0]}; W=8 replaces the whole byte with data_s_i.
REQ-020 data_s_o SHALL be combinational from data_p_o: lane k (k<W) = data_p_o[8-W+k]; lanes k>=W SHALL drive 1.
REQ-021 Shift counter SHALL count shifts 0..N-1 and wrap to 0 on the N-th shift; shifting SHALL continue across byte boundaries without a reload (streaming).
REQ-022 byte_done_o SHALL be registered, asserting for exactly one clk_i cycle, in the cycle after the shift that wraps the counter; it SHALL not assert on load.
REQ-023 Mode changes on wide_i between loads SHALL have no effect until the next load.
REQ-024 CRC per lane: polynomial x^16+x^12+x^5+1, init 0x0000, MSB-first; per shift, for each lane k<W: fb = crc[15] ^ bit, crc <= {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0); bit = data_s_o[k] before the shift when dir_i=1, data_s_i[k] when dir_i=0.
REQ-025 Lanes k>=W SHALL hold their CRC unchanged during shifts.
REQ-026 crc_clr_i SHALL set every CRC to 0x0000 and wins over a coincident CRC update (that bit is discarded); it SHALL not affect data_p_o, counter or mode.

Reset
REQ-027 rst_i=1 SHALL, at the next rising clk_i edge and with priority over load, shift and clear, set data_p_o=8'hFF, counter=0, mode=narrow, byte_done_o=0, all CRCs=0x0000; data_s_o is therefore all ones.
REQ-028 Reset asserted mid-byte SHALL abandon the byte; no byte_done_o pulse SHALL follow.

Verification
REQ-029 Reset: assert rst_i one cycle, any stimulus -> data_p_o=8'hFF, data_s_o all ones, crc_o all zero, byte_done_o=0.
REQ-030 Wide, LANES=4: load 8'hA5 wide_i=1; two shift strobes with data_s_i=4'h3 then 4'hC -> data_s_o 4'hA then 4'h5; data_p_o=8'h3C; byte_done_o one pulse after second shift.
REQ-031 Narrow: load 8'h81 wide_i=0; eight shift strobes, data_s_i=0 -> data_s_o[0] sequence 1,0,0,0,0,0,0,1; data_s_o[3:1]=3'b111; data_p_o=8'h00; one byte_done_o.
REQ-032 CRC transmit: crc_clr_i, load 8'hFF narrow, dir_i=1, eight shifts -> crc_o lane 0 = 16'h1EF0, lanes 1-3 = 16'h0000.
REQ-033 Priority: load_p_i with clkstrb_i and shift_s_i same cycle -> data_p_o = data_p_i, counter 0, no CRC change; shift_s_i=1 with clkstrb_i=0 for 10 cycles -> no change.
REQ-034 Reset mid-byte: wide load, one shift, rst_i -> reset values of REQ-027, no byte_done_o in following 4 cycles.
